// File: rtl/hz_pkg.sv
// Shared hazard-control encodings and mult/div FSM state values.
package hz_pkg;

   typedef logic [1:0] hz_ctrl_t;

   localparam hz_ctrl_t HZ_NORMAL = 2'b00;
   localparam hz_ctrl_t HZ_FLUSH  = 2'b01;
   localparam hz_ctrl_t HZ_STALL  = 2'b10;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/md_stall_ctr.sv
// Tracks how long a mult/div op has occupied EX and raises MdStall
// for MD_LAT-1 cycles of each op.
module md_stall_ctr
   import hz_pkg::*;
#(
   parameter int MD_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ID_EX_MdOp,
   output logic MdStall
);

   localparam logic [3:0] CNT_INIT = (MD_LAT > 1) ? 4'(MD_LAT - 2) : 4'd0;
   localparam logic       MD_MULTI = (MD_LAT > 1);

   logic       state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       start;

   assign start = (state_q == ST_IDLE) & ID_EX_MdOp & MD_MULTI;

   // Gated by rst so an asserted reset drops the stall in the same cycle.
   assign MdStall = rst & (start | ((state_q == ST_BUSY) & (cnt_q != 4'd0)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
         end
      end else begin
         // The release cycle ignores ID_EX_MdOp; a following op is taken from IDLE.
         if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: prioritised stall/flush codes for PC, IF/ID and
// ID/EX, plus saturating stall/flush performance counters.
module hazard_unit
   import hz_pkg::*;
#(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IF_ID_RsAddr,
   input  logic [4:0]       IF_ID_RtAddr,
   input  logic             UseRs,
   input  logic             UseRt,
   input  logic             ID_Jump,
   input  logic             ID_EX_MemRd,
   input  logic [4:0]       ID_EX_RtAddr,
   input  logic             ID_EX_MdOp,
   input  logic             EX_BrTaken,
   input  logic             CntClr,
   output logic [1:0]       PC_HzCtrl,
   output logic [1:0]       IF_ID_HzCtrl,
   output logic [1:0]       ID_EX_HzCtrl,
   output logic             MdBusy,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             md_stall;
   logic             load_use;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   md_stall_ctr #(.MD_LAT(MD_LAT)) u_md_stall_ctr (
      .clk        (clk),
      .rst        (rst),
      .ID_EX_MdOp (ID_EX_MdOp),
      .MdStall    (md_stall)
   );

   assign load_use = ID_EX_MemRd & (ID_EX_RtAddr != 5'd0) &
                     ((UseRs & (ID_EX_RtAddr == IF_ID_RsAddr)) |
                      (UseRt & (ID_EX_RtAddr == IF_ID_RtAddr)));

   always_comb begin
      PC_HzCtrl    = HZ_NORMAL;
      IF_ID_HzCtrl = HZ_NORMAL;
      ID_EX_HzCtrl = HZ_NORMAL;
      MdBusy       = 1'b0;
      if (EX_BrTaken) begin
         IF_ID_HzCtrl = HZ_FLUSH;
         ID_EX_HzCtrl = HZ_FLUSH;
      end else if (md_stall) begin
         PC_HzCtrl    = HZ_STALL;
         IF_ID_HzCtrl = HZ_STALL;
         ID_EX_HzCtrl = HZ_STALL;
         MdBusy       = 1'b1;
      end else if (load_use) begin
         // Freeze the front end and push a bubble into EX.
         PC_HzCtrl    = HZ_STALL;
         IF_ID_HzCtrl = HZ_STALL;
         ID_EX_HzCtrl = HZ_FLUSH;
      end else if (ID_Jump) begin
         IF_ID_HzCtrl = HZ_FLUSH;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (CntClr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if ((PC_HzCtrl == HZ_STALL) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         if ((IF_ID_HzCtrl == HZ_FLUSH) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, random patterns against a
// priority model, and hand-written mult/div, reset and saturation sequences.
module tb_hazard_unit;

   localparam int MD_LAT = 4;
   localparam int CNT_W  = 16;

   // {PC, IF_ID, ID_EX, MdBusy}
   localparam logic [6:0] E_IDLE = 7'b00_00_00_0;
   localparam logic [6:0] E_MD   = 7'b10_10_10_1;
   localparam logic [6:0] E_LU   = 7'b10_10_01_0;
   localparam logic [6:0] E_JMP  = 7'b00_01_00_0;
   localparam logic [6:0] E_BR   = 7'b00_01_01_0;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic       jump;
      logic       memrd;
      logic [4:0] ex_rt;
      logic       br;
      logic [6:0] exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       IF_ID_RsAddr, IF_ID_RtAddr, ID_EX_RtAddr;
   logic             UseRs, UseRt, ID_Jump, ID_EX_MemRd, ID_EX_MdOp, EX_BrTaken, CntClr;
   logic [1:0]       PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl;
   logic             MdBusy;
   logic [CNT_W-1:0] StallCnt, FlushCnt;

   int               n_pass = 0;
   int               n_total = 0;
   logic [6:0]       exp_q[$];
   logic [CNT_W-1:0] exp_stall, exp_flush;

   always #5 clk = ~clk;

   hazard_unit #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .IF_ID_RsAddr (IF_ID_RsAddr),
      .IF_ID_RtAddr (IF_ID_RtAddr),
      .UseRs        (UseRs),
      .UseRt        (UseRt),
      .ID_Jump      (ID_Jump),
      .ID_EX_MemRd  (ID_EX_MemRd),
      .ID_EX_RtAddr (ID_EX_RtAddr),
      .ID_EX_MdOp   (ID_EX_MdOp),
      .EX_BrTaken   (EX_BrTaken),
      .CntClr       (CntClr),
      .PC_HzCtrl    (PC_HzCtrl),
      .IF_ID_HzCtrl (IF_ID_HzCtrl),
      .ID_EX_HzCtrl (ID_EX_HzCtrl),
      .MdBusy       (MdBusy),
      .StallCnt     (StallCnt),
      .FlushCnt     (FlushCnt)
   );

   function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic ur, logic ut,
                               logic j, logic mr, logic [4:0] ert, logic br,
                               logic [6:0] exp);
      vec_t v;
      v.rs = rs; v.rt = rt; v.use_rs = ur; v.use_rt = ut;
      v.jump = j; v.memrd = mr; v.ex_rt = ert; v.br = br; v.exp = exp;
      return v;
   endfunction

   function automatic logic [6:0] model(vec_t v);
      logic lu;
      lu = v.memrd && (v.ex_rt != 5'd0) &&
           ((v.use_rs && (v.ex_rt == v.rs)) || (v.use_rt && (v.ex_rt == v.rt)));
      if (v.br)   return E_BR;
      if (lu)     return E_LU;
      if (v.jump) return E_JMP;
      return E_IDLE;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + CNT_W'(1);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic drive(vec_t v, logic md, logic clr);
      rst          = 1'b1;
      IF_ID_RsAddr = v.rs;
      IF_ID_RtAddr = v.rt;
      UseRs        = v.use_rs;
      UseRt        = v.use_rt;
      ID_Jump      = v.jump;
      ID_EX_MemRd  = v.memrd;
      ID_EX_RtAddr = v.ex_rt;
      EX_BrTaken   = v.br;
      ID_EX_MdOp   = md;
      CntClr       = clr;
   endtask

   // One clock: drive after the edge, compare outputs and counters mid-cycle.
   task automatic step(string name, vec_t v, logic md, logic clr, logic [6:0] exp);
      logic [6:0] got, req;
      @(posedge clk);
      #1;
      drive(v, md, clr);
      exp_q.push_back(exp);
      @(negedge clk);
      got = {PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl, MdBusy};
      if (exp_q.size() == 0) begin
         check({name, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         req = exp_q.pop_front();
         check(name, 32'(got), 32'(req));
      end
      check({name, "_stall_cnt"}, 32'(StallCnt), 32'(exp_stall));
      check({name, "_flush_cnt"}, 32'(FlushCnt), 32'(exp_flush));
      if (clr) begin
         exp_stall = '0;
         exp_flush = '0;
      end else begin
         if (exp[6:5] == 2'b10) exp_stall = sat_inc(exp_stall);
         if (exp[4:3] == 2'b01) exp_flush = sat_inc(exp_flush);
      end
   endtask

   initial begin
      vec_t idle_v, lu_v, rv;
      vec_t tbl[12];

      idle_v = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_IDLE);
      lu_v   = mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, E_LU);

      tbl[0]  = idle_v;
      tbl[1]  = lu_v;
      tbl[2]  = mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, E_IDLE);
      tbl[3]  = mk(5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_LU);
      tbl[4]  = mk(5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, E_IDLE);
      tbl[5]  = mk(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, E_IDLE);
      tbl[6]  = mk(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, E_JMP);
      tbl[7]  = mk(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, E_LU);
      tbl[8]  = mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, E_BR);
      tbl[9]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_BR);
      tbl[10] = mk(5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, E_IDLE);
      tbl[11] = mk(5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, E_LU);

      // Reset held with a mult/div in EX: everything quiet.
      drive(idle_v, 1'b1, 1'b0);
      rst = 1'b0;
      exp_stall = '0;
      exp_flush = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 32'({PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl, MdBusy}), 32'(E_IDLE));
      check("reset_stall_cnt", 32'(StallCnt), 32'd0);
      check("reset_flush_cnt", 32'(FlushCnt), 32'd0);

      // Release: the pending op stalls at once, then a back-to-back second op.
      for (int op = 0; op < 2; op++) begin
         for (int c = 0; c < MD_LAT - 1; c++)
            step($sformatf("md%0d_busy%0d", op, c), idle_v, 1'b1, 1'b0, E_MD);
         step($sformatf("md%0d_release", op), idle_v, 1'b1, 1'b0, E_IDLE);
      end
      step("md_after", idle_v, 1'b0, 1'b0, E_IDLE);
      check("md_stall_total", 32'(StallCnt), 32'd6);

      for (int i = 0; i < 12; i++)
         step($sformatf("vec%0d", i), tbl[i], 1'b0, 1'b0, tbl[i].exp);

      for (int i = 0; i < 40; i++) begin
         rv = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), E_IDLE);
         rv.exp = model(rv);
         step($sformatf("rand%0d", i), rv, 1'b0, 1'b0, rv.exp);
      end

      // Reset in the second busy cycle aborts the stall immediately.
      step("abort_busy0", idle_v, 1'b1, 1'b0, E_MD);
      step("abort_busy1", idle_v, 1'b1, 1'b0, E_MD);
      #1;
      rst = 1'b0;
      #1;
      check("abort_ctrl", 32'({PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl, MdBusy}), 32'(E_IDLE));
      check("abort_stall_cnt", 32'(StallCnt), 32'd0);
      exp_stall = '0;
      exp_flush = '0;
      step("abort_idle", idle_v, 1'b0, 1'b0, E_IDLE);
      for (int c = 0; c < MD_LAT - 1; c++)
         step($sformatf("restart_busy%0d", c), idle_v, 1'b1, 1'b0, E_MD);
      step("restart_release", idle_v, 1'b1, 1'b0, E_IDLE);

      // Saturation of the stall counter, then a one-cycle clear.
      step("sat_start", lu_v, 1'b0, 1'b0, E_LU);
      repeat (65541) @(posedge clk);
      @(negedge clk);
      check("sat_stall_cnt", 32'(StallCnt), 32'hFFFF);
      exp_stall = '1;
      step("sat_clr", lu_v, 1'b0, 1'b1, E_LU);
      step("after_clr", idle_v, 1'b0, 1'b0, E_IDLE);
      step("final_idle", idle_v, 1'b0, 1'b0, E_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller driving the 2-bit hazard-control codes consumed by the PC register, IF/ID and ID/EX stage registers (00 normal, 01 flush, 10 stall). Detects load-use hazards, ID-resolved jumps, EX-resolved taken branches and multi-cycle multiply/divide occupancy of EX. Holds a small FSM/counter for mult/div latency and saturating stall/flush performance counters. Sits beside the ID stage; its outputs are combinational for the current cycle and take effect at the next clock edge in the stage registers.

## Interface
- MD_LAT, 4: total cycles a mult/div op occupies EX (1..15; 1 = no stall)
- CNT_W, 16: width of performance counters
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- IF_ID_RsAddr  in  5  rs field of instruction in ID
- IF_ID_RtAddr  in  5  rt field of instruction in ID
- UseRs  in  1  ID instruction reads rs
- UseRt  in  1  ID instruction reads rt
- ID_Jump  in  1  ID instruction is j/jal/jr/jalr (PCSrc resolved in ID)
- ID_EX_MemRd  in  1  instruction in EX is a load
- ID_EX_RtAddr  in  5  load destination in EX
- ID_EX_MdOp  in  1  instruction in EX is mult/div
- EX_BrTaken  in  1  branch in EX resolved taken
- CntClr  in  1  synchronous clear of performance counters
- PC_HzCtrl  out  2  00 update, 10 hold
- IF_ID_HzCtrl  out  2  00/01/10
- ID_EX_HzCtrl  out  2  00/01/10
- MdBusy  out  1  EX holding a mult/div; EX/MEM must insert bubble
- StallCnt  out  CNT_W  cycles with PC_HzCtrl = 10
- FlushCnt  out  CNT_W  cycles with IF_ID_HzCtrl = 01

## Operation
- Hazard conditions:
  - LoadUse = ID_EX_MemRd & ID_EX_RtAddr != 0 & ((UseRs & ID_EX_RtAddr == IF_ID_RsAddr) | (UseRt & ID_EX_RtAddr == IF_ID_RtAddr)).
  - MdStall = (state IDLE & ID_EX_MdOp & MD_LAT > 1) | (state BUSY & cnt != 0).
- Priority, first match wins:
  1. EX_BrTaken: PC 00, IF_ID 01, ID_EX 01.
  2. MdStall: PC 10, IF_ID 10, ID_EX 10, MdBusy 1.
  3. LoadUse: PC 10, IF_ID 10, ID_EX 01 (bubble).
  4. ID_Jump: PC 00, IF_ID 01, ID_EX 00.
  5. Otherwise all 00, MdBusy 0.
- EX_BrTaken together with MdStall cannot occur legally; priority above still applies.
- Mult/div FSM, states IDLE and BUSY, down-counter cnt of 4 bits:
  - IDLE & ID_EX_MdOp & MD_LAT > 1: cnt <= MD_LAT-2, go BUSY.
  - BUSY & cnt != 0: cnt <= cnt-1, stay BUSY.
  - BUSY & cnt == 0: release (no MdStall), go IDLE. ID_EX_MdOp is ignored in this cycle.
  - Back-to-back mult/div: the next op is seen in IDLE on the following cycle.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones. CntClr has priority over increment and forces 0.

## Timing
- Reset (rst = 0, async): state IDLE, cnt 0, StallCnt 0, FlushCnt 0. Outputs follow the combinational rules with the FSM idle, so all HzCtrl are 00 and MdBusy is 0 when inputs are quiescent.
- Reset asserted mid-BUSY aborts the stall immediately, not at the next edge.
- HzCtrl and MdBusy are combinational, zero-cycle latency. The FSM and counters update on the rising edge of clk.
- Load-use costs exactly 1 stall cycle, and the hazard clears once the bubble reaches EX.
- A mult/div op occupies EX for exactly MD_LAT cycles: MdStall is high for MD_LAT-1 cycles, then release.
- Counters reflect the previous cycle's outputs, one-cycle lag.

## Structure
- Shared package hz_pkg holds:
  - HZ_NORMAL = 2'b00, HZ_FLUSH = 2'b01, HZ_STALL = 2'b10.
  - FSM state encoding (IDLE = 0, BUSY = 1).
- Sub-module md_stall_ctr owns the FSM and cnt. It takes ID_EX_MdOp and outputs MdStall.
- Priority mux and perf counters live in hazard_unit.

## Test plan
- Reset: hold rst = 0 with ID_EX_MdOp = 1 -> all HzCtrl 00, MdBusy 0, counters 0. Release rst -> MdStall asserts that cycle.
- Load-use: ID_EX_MemRd = 1, ID_EX_RtAddr = 8, IF_ID_RsAddr = 8, UseRs = 1 -> PC 10, IF_ID 10, ID_EX 01 for 1 cycle, then StallCnt = 1. Repeat with RtAddr = 0 -> no stall.
- Taken branch plus load-use plus ID_Jump in the same cycle -> PC 00, IF_ID 01, ID_EX 01. FlushCnt increments by 1.
- MD_LAT = 4: pulse ID_EX_MdOp held by stall -> MdBusy high for 3 cycles, then 00 on cycle 4. Back-to-back second op -> 3 more stall cycles, StallCnt = 6.
- Reset mid-op: assert rst during BUSY cycle 2 -> outputs 00 immediately, state IDLE after release.
- Saturation: force 2^16+5 stall cycles -> StallCnt = 16'hFFFF. CntClr for one cycle -> 0.
